status_ctrl: RTL and testbench

Write-port controller for the STATUS register. It merges four sources into the register's single write port (`status_wr` / `status_reg_in`):
- core writes to the STATUS file address;
- ALU flag updates;
- watchdog/power events (CLRWDT, SLEEP, WDT time-out);
- the power-up initialisation write.

It also tracks the core's run/sleep state. It sits between the instruction decoder/ALU and the STATUS register, and reads the register's current value back on `status_cur`.

---
 rtl/status_ctrl.sv | 118 +++++++++++
 tb/tb_status_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/status_ctrl.sv
// STATUS register write-port controller: merges core, ALU and watchdog/power
// updates into one write port and tracks the core's run/sleep state.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_INIT  | first cycle after reset, writes POR_VALUE
// ST_RUN   | core executing, requests merged onto status_cur
// ST_SLEEP | core halted, waiting for watchdog time-out or wake
module status_ctrl #(
  parameter logic [7:0] POR_VALUE = 8'h18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] status_cur,
  input  logic       fw_req,
  input  logic [7:0] fw_data,
  input  logic       alu_req,
  input  logic [2:0] alu_mask,
  input  logic [2:0] alu_flags,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       wdt_to,
  input  logic       wake,
  output logic       status_wr,
  output logic [7:0] status_reg_in,
  output logic       ready,
  output logic       sleeping
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] run_data;
  logic       run_wr;

  // Merge order matters: each later source overrides the earlier ones.
  always_comb begin
    run_data = status_cur;
    if (fw_req) begin
      run_data[7:5] = fw_data[7:5];
      run_data[2:0] = fw_data[2:0];
    end
    if (alu_req)
      run_data[2:0] = (run_data[2:0] & ~alu_mask) | (alu_flags & alu_mask);
    if (clrwdt) run_data[4:3] = 2'b11;
    if (sleep)  run_data[4:3] = 2'b10;
    if (wdt_to) run_data[4]   = 1'b0;
    run_wr = fw_req | (alu_req & (alu_mask != 3'b000)) | clrwdt | sleep | wdt_to;
  end

  // rst gates the write port directly so an in-flight write drops without a clock.
  always_comb begin
    status_wr     = 1'b0;
    status_reg_in = 8'h00;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          status_wr     = 1'b1;
          status_reg_in = POR_VALUE;
        end
        ST_RUN: begin
          status_wr     = run_wr;
          status_reg_in = run_data;
        end
        ST_SLEEP: begin
          if (wdt_to) begin
            status_wr     = 1'b1;
            status_reg_in = {status_cur[7:5], 2'b00, status_cur[2:0]};
          end
        end
        default: begin
          status_wr     = 1'b0;
          status_reg_in = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      ready    <= 1'b0;
      sleeping <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          state    <= ST_RUN;
          ready    <= 1'b1;
          sleeping <= 1'b0;
        end
        ST_RUN: begin
          if (sleep) begin
            state    <= ST_SLEEP;
            ready    <= 1'b0;
            sleeping <= 1'b1;
          end
        end
        ST_SLEEP: begin
          if (wdt_to || wake) begin
            state    <= ST_RUN;
            ready    <= 1'b1;
            sleeping <= 1'b0;
          end
        end
        default: begin
          state    <= ST_INIT;
          ready    <= 1'b0;
          sleeping <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_ctrl.sv
// Self-checking bench for status_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_status_ctrl;

  localparam logic [7:0] POR = 8'h18;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] stat;
  logic       fw_req, alu_req, clrwdt, sleep, wdt_to, wake;
  logic [7:0] fw_data;
  logic [2:0] alu_mask, alu_flags;
  logic       status_wr, ready, sleeping;
  logic [7:0] status_reg_in;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = init cycle, 1 = running, 2 = asleep.
  int         md;
  logic       exp_wr, exp_ready, exp_sleeping;
  logic [7:0] exp_data;

  always #5 clk = ~clk;

  status_ctrl #(.POR_VALUE(POR)) dut (
    .clk(clk), .rst(rst), .status_cur(stat),
    .fw_req(fw_req), .fw_data(fw_data),
    .alu_req(alu_req), .alu_mask(alu_mask), .alu_flags(alu_flags),
    .clrwdt(clrwdt), .sleep(sleep), .wdt_to(wdt_to), .wake(wake),
    .status_wr(status_wr), .status_reg_in(status_reg_in),
    .ready(ready), .sleeping(sleeping)
  );

  always @* begin
    exp_wr       = 1'b0;
    exp_data     = 8'h00;
    exp_ready    = !rst && md == 1;
    exp_sleeping = !rst && md == 2;
    if (!rst) begin
      if (md == 0) begin
        exp_wr   = 1'b1;
        exp_data = POR;
      end else if (md == 1) begin
        for (int i = 0; i < 8; i++) begin
          if (i == 3 || i == 4) exp_data[i] = stat[i];
          else                  exp_data[i] = fw_req ? fw_data[i] : stat[i];
        end
        for (int i = 0; i < 3; i++)
          if (alu_req && alu_mask[i]) exp_data[i] = alu_flags[i];
        exp_data[4] = wdt_to ? 1'b0 : ((sleep || clrwdt) ? 1'b1 : stat[4]);
        exp_data[3] = sleep ? 1'b0 : (clrwdt ? 1'b1 : stat[3]);
        exp_wr = fw_req || (alu_req && alu_mask != 0) || clrwdt || sleep || wdt_to;
      end else if (wdt_to) begin
        exp_wr   = 1'b1;
        exp_data = stat & 8'hE7;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) md <= 0;
    else begin
      if (exp_wr) stat <= exp_data;
      case (md)
        0:       md <= 1;
        1:       if (sleep) md <= 2;
        default: if (wdt_to || wake) md <= 1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("status_wr", {7'd0, status_wr}, {7'd0, exp_wr});
    if (exp_wr || rst) chk("status_reg_in", status_reg_in, exp_data);
    chk("ready", {7'd0, ready}, {7'd0, exp_ready});
    chk("sleeping", {7'd0, sleeping}, {7'd0, exp_sleeping});
  end

  task automatic idle();
    fw_req = 0; fw_data = 0; alu_req = 0; alu_mask = 0; alu_flags = 0;
    clrwdt = 0; sleep = 0; wdt_to = 0; wake = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    rst = 1'b1; stat = 8'h00; idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("init_wr", {7'd0, status_wr}, 8'd1);
    chk("init_data", status_reg_in, 8'h18);
    chk("init_ready", {7'd0, ready}, 8'd0);

    next(); chk("run_ready", {7'd0, ready}, 8'd1);
    stat = 8'h18; fw_req = 1; fw_data = 8'hE7;
    #2 chk("ro_bits", status_reg_in, 8'hFF);

    next(); stat = 8'h18; fw_req = 1; fw_data = 8'h01;
    alu_req = 1; alu_mask = 3'b101; alu_flags = 3'b100;
    #2 chk("flag_merge", status_reg_in, 8'h1C);

    next(); alu_req = 1; alu_mask = 3'b000; alu_flags = 3'b111;
    #2 chk("alu_mask0_wr", {7'd0, status_wr}, 8'd0);

    next(); wake = 1;
    next(); chk("wake_in_run", {7'd0, ready}, 8'd1);

    stat = 8'h18; sleep = 1;
    #2 chk("sleep_data", status_reg_in, 8'h10);
    next(); chk("sleeping", {7'd0, sleeping}, 8'd1);
    fw_req = 1; fw_data = 8'hFF;
    #2 chk("fw_in_sleep", {7'd0, status_wr}, 8'd0);
    next(); wdt_to = 1;
    #2 chk("wdt_wake_data", status_reg_in, 8'h00);
    next(); chk("wdt_back_run", {7'd0, ready}, 8'd1);

    stat = 8'h18; clrwdt = 1; sleep = 1; wdt_to = 1;
    #2 chk("simul_data", status_reg_in, 8'h00);
    next(); chk("simul_sleep", {7'd0, sleeping}, 8'd1);
    stat = 8'hFF; wake = 1; wdt_to = 1;
    #2 chk("wake_wdt_data", status_reg_in, 8'hE7);
    next(); chk("wake_wdt_run", {7'd0, ready}, 8'd1);

    sleep = 1;
    next(); wdt_to = 1;
    #2 chk("pre_rst_wr", {7'd0, status_wr}, 8'd1);
    rst = 1'b1;
    #1 chk("async_wr", {7'd0, status_wr}, 8'd0);
    chk("async_sleeping", {7'd0, sleeping}, 8'd0);
    @(posedge clk); #1 idle(); stat = 8'h00; rst = 1'b0;
    #2 chk("reinit_data", status_reg_in, 8'h18);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      idle();
      if (rst) rst = 1'b0;
      else if ($urandom_range(199) == 0) rst = 1'b1;
      fw_req    = ($urandom_range(3) == 0);
      fw_data   = 8'($urandom);
      alu_req   = ($urandom_range(2) == 0);
      alu_mask  = 3'($urandom);
      alu_flags = 3'($urandom);
      clrwdt    = ($urandom_range(7) == 0);
      sleep     = ($urandom_range(9) == 0);
      wdt_to    = ($urandom_range(11) == 0);
      wake      = ($urandom_range(5) == 0);
      if ($urandom_range(15) == 0) stat = 8'($urandom);
    end

    next();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
